uart_word_packer: RTL and testbench
===================================

Name: uart_word_packer

Overview:
- Parametrised successor of the serial-byte-to-pixel assembler in the VGA serial display path.
- Collects BYTES_PER_WORD bytes from the UART receiver and packs them into one word with selectable byte order.
- Emits a single-cycle write strobe with an auto-incrementing, wrapping address into the frame RAM.
- Adds what the previous generation lacked: inter-byte timeout resync, software clear, frame-done pulse, and no byte loss during the write cycle.

Parameters:
- BYTE_W, 8, width of one received byte.
- BYTES_PER_WORD, 3, bytes packed per RAM word (>=1).
- DEPTH, 129600, number of RAM words; address wraps after DEPTH-1.
- ADDR_W, 17, address width; must satisfy 2**ADDR_W >= DEPTH.
- MSB_FIRST, 0, 0: first byte lands in the least-significant lane; 1: first byte lands in the most-significant lane.
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of a partial word; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  BYTE_W  received byte.
- clear  in  1  synchronous restart: drops any partial word, address returns to 0.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_data  out  BYTE_W*BYTES_PER_WORD  packed word.
- wr_addr  out  ADDR_W  RAM address for the write.
- frame_done  out  1  one-cycle pulse coincident with the write to address DEPTH-1.
- timeout_err  out  1  one-cycle pulse when a partial word is discarded by timeout.
- partial  out  1  high while 1..BYTES_PER_WORD-1 bytes of a word are held.

Behaviour:
- Reset (asynchronous): wr_en=0, wr_data=0, wr_addr=0, frame_done=0, timeout_err=0, partial=0. Byte index=0, timeout counter=0, state=COLLECT.
- States:
  - COLLECT: waits for bytes.
  - WRITE: one cycle, asserts wr_en.
- Lane mapping: byte number k (0 = first received) goes to lane k when MSB_FIRST=0, or to lane BYTES_PER_WORD-1-k when MSB_FIRST=1. Lane j occupies bits [BYTE_W*j+BYTE_W-1 : BYTE_W*j].
- Byte accept: on an rx_valid edge in COLLECT, the byte is stored in its lane and the byte index increments.
- Last byte: when byte k=BYTES_PER_WORD-1 is accepted at edge N:
  - state becomes WRITE;
  - during cycle N+1: wr_en=1, wr_data=the packed word, wr_addr=current address;
  - at edge N+2: address increments, or wraps to 0 if it was DEPTH-1. Latency from last byte to strobe is 1 clock.
- Lane contents: unused lanes hold their previous values. No zero-fill is guaranteed between words. All lanes are overwritten each word.
- wr_data and wr_addr hold their values while wr_en=0.
- rx_valid in WRITE: the byte is accepted as byte 0 of the next word. It lands in its lane and is not dropped; state returns to COLLECT.
- Back-to-back: BYTES_PER_WORD=1 with rx_valid every cycle produces wr_en every cycle with consecutive addresses.
- frame_done: asserted in the same cycle as wr_en when wr_addr=DEPTH-1.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter runs only while partial=1 and resets on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: byte index goes to 0, partial goes to 0, timeout_err pulses for one cycle, and the address is unchanged.
  - An rx_valid on the expiry cycle is taken as byte 0 of a new word.
- clear:
  - Highest priority: byte index goes to 0, address goes to 0, timeout counter goes to 0, state goes to COLLECT.
  - rx_valid in the same cycle is dropped.
  - If the final byte arrives in the same cycle as clear, no write is issued.
  - If clear is high during the WRITE cycle, the strobe still occurs (it is already registered), and the next address is 0.
- Widths: address arithmetic is done in ADDR_W bits with an explicit compare against DEPTH-1. It never relies on natural overflow.
- Reset mid-word: all collection state is lost immediately (asynchronous); no write is produced.

Test Plan:
1. Defaults, bytes 0x11, 0x22, 0x33 with gaps of 5 clocks → exactly one wr_en, wr_data=0x332211, wr_addr=0, asserted 1 clock after the 0x33 edge. Next word uses wr_addr=1.
2. MSB_FIRST=1, bytes 0xAA, 0xBB, 0xCC → wr_data=0xAABBCC.
3. DEPTH=4, 12 bytes → addresses 0, 1, 2, 3 with frame_done only on address 3. The 13th–15th bytes write to address 0.
4. TIMEOUT_CYCLES=10, send 0x01, 0x02, idle 10 clocks → timeout_err for one cycle, no wr_en. Then 0x05, 0x06, 0x07 → wr_data=0x070605 at the unchanged address.
5. BYTES_PER_WORD=3, byte 3 of word A and byte 0 of word B arrive on consecutive clocks (rx_valid during WRITE) → both words are written correctly with no byte lost.
6. After 2 words, send 1 byte, then pulse clear together with rx_valid → byte dropped, partial=0. Next 3 bytes write to wr_addr=0. Assert reset mid-word → all outputs read 0 asynchronously.

Source files
------------

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs BYTES_PER_WORD serial bytes into one RAM word,
// with a wrapping write address, inter-byte timeout resync and clear.
module uart_word_packer #(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 3,
  parameter int DEPTH          = 129600,
  parameter int ADDR_W         = 17,
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rx_valid,
  input  logic [BYTE_W-1:0]                rx_data,
  input  logic                             clear,
  output logic                             wr_en,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] wr_data,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic                             frame_done,
  output logic                             timeout_err,
  output logic                             partial
);

  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [IW-1:0]     LAST_IDX  = IW'(BYTES_PER_WORD - 1);
  localparam logic [CW-1:0]     TO_LAST   = CW'(TO_M1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    COLLECT,
    WRITE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] ptr;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] lanes;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] lanes_nx;

  logic              accept;
  logic              expire;
  logic              last;
  logic [IW-1:0]     k;
  logic [IW-1:0]     lane_sel;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] base;

  assign wr_en      = (state == WRITE);
  assign partial    = (idx != '0);
  assign frame_done = wr_en && (wr_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = COLLECT;
    accept   = rx_valid && !clear;
    expire   = TO_EN && partial && !clear && (cnt == TO_LAST);
    // a byte arriving on the expiry cycle starts a fresh word
    k        = expire ? '0 : idx;
    last     = accept && (k == LAST_IDX);
    lane_sel = (MSB_FIRST != 0) ? (LAST_IDX - k) : k;
    lanes_nx = lanes;
    if (accept) lanes_nx[lane_sel] = rx_data;
    ptr_inc  = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
    base     = (state == WRITE) ? ptr_inc : ptr;
    unique case (state)
      COLLECT: if (last) state_nx = WRITE;
      WRITE:   if (last) state_nx = WRITE;
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      cnt         <= '0;
      ptr         <= '0;
      lanes       <= '0;
      wr_data     <= '0;
      wr_addr     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (clear) begin
        idx <= '0;
        cnt <= '0;
        ptr <= '0;
      end else begin
        if (state == WRITE) ptr <= ptr_inc;
        if (accept) begin
          lanes <= lanes_nx;
          cnt   <= '0;
          idx   <= last ? '0 : k + IW'(1);
          if (last) begin
            wr_data <= lanes_nx;
            wr_addr <= base;
          end
        end else if (expire || !partial) begin
          idx <= expire ? '0 : idx;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer: directed + random stimulus against a queue-based
// reference model for three packer configurations.
module tb_uart_word_packer;

  localparam int DEPTH_AB = 4;
  localparam int TO_AB    = 10;
  localparam int DEPTH_C  = 5;

  logic clk;
  logic reset;
  logic rx_valid;
  logic [7:0] rx_data;
  logic clear;
  logic c_valid;
  logic [7:0] c_data;
  logic c_clear;

  logic a_wr_en, a_frame_done, a_timeout_err, a_partial;
  logic [23:0] a_wr_data;
  logic [1:0] a_wr_addr;
  logic b_wr_en, b_frame_done, b_timeout_err, b_partial;
  logic [23:0] b_wr_data;
  logic [1:0] b_wr_addr;
  logic c_wr_en, c_frame_done, c_timeout_err, c_partial;
  logic [7:0] c_wr_data;
  logic [2:0] c_wr_addr;

  int n_tests = 0;
  int n_fail  = 0;

  uart_word_packer #(
    .BYTE_W(8), .BYTES_PER_WORD(3), .DEPTH(DEPTH_AB), .ADDR_W(2),
    .MSB_FIRST(0), .TIMEOUT_CYCLES(TO_AB)
  ) dut_a (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .clear(clear), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .wr_addr(a_wr_addr), .frame_done(a_frame_done),
    .timeout_err(a_timeout_err), .partial(a_partial)
  );

  uart_word_packer #(
    .BYTE_W(8), .BYTES_PER_WORD(3), .DEPTH(DEPTH_AB), .ADDR_W(2),
    .MSB_FIRST(1), .TIMEOUT_CYCLES(TO_AB)
  ) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .clear(clear), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .wr_addr(b_wr_addr), .frame_done(b_frame_done),
    .timeout_err(b_timeout_err), .partial(b_partial)
  );

  uart_word_packer #(
    .BYTE_W(8), .BYTES_PER_WORD(1), .DEPTH(DEPTH_C), .ADDR_W(3),
    .MSB_FIRST(0), .TIMEOUT_CYCLES(0)
  ) dut_c (
    .clk(clk), .reset(reset), .rx_valid(c_valid), .rx_data(c_data),
    .clear(c_clear), .wr_en(c_wr_en), .wr_data(c_wr_data),
    .wr_addr(c_wr_addr), .frame_done(c_frame_done),
    .timeout_err(c_timeout_err), .partial(c_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state for dut_a / dut_b (shared inputs)
  logic [7:0] q[$];
  int addr, idle, exp_waddr;
  bit exp_wr, exp_to;
  logic [23:0] exp_wl, exp_wm;
  // reference model state for dut_c
  int c_addr, c_exp_waddr;
  bit c_exp_wr;
  logic [7:0] c_exp_data;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    addr = 0; idle = 0; exp_waddr = 0;
    exp_wr = 0; exp_to = 0;
    exp_wl = '0; exp_wm = '0;
    c_addr = 0; c_exp_waddr = 0; c_exp_wr = 0; c_exp_data = '0;
  endtask

  task automatic model_ab(input bit v, input logic [7:0] d, input bit c);
    bit new_wr, new_to;
    new_wr = 0;
    new_to = 0;
    if (c) begin
      q.delete();
      addr = 0;
      idle = 0;
    end else begin
      if (exp_wr) addr = (addr + 1) % DEPTH_AB;
      if (q.size() > 0 && idle + 1 == TO_AB) begin
        q.delete();
        new_to = 1;
        idle = 0;
      end
      if (v) begin
        q.push_back(d);
        idle = 0;
        if (q.size() == 3) begin
          exp_wl = '0;
          exp_wm = '0;
          for (int i = 0; i < 3; i++) begin
            exp_wl |= 24'(q[i]) << (8 * i);
            exp_wm |= 24'(q[i]) << (8 * (2 - i));
          end
          exp_waddr = addr;
          new_wr = 1;
          q.delete();
        end
      end else if (q.size() > 0) begin
        idle++;
      end else begin
        idle = 0;
      end
    end
    exp_wr = new_wr;
    exp_to = new_to;
  endtask

  task automatic model_c(input bit v, input logic [7:0] d);
    if (c_exp_wr) c_addr = (c_addr + 1) % DEPTH_C;
    c_exp_wr = v;
    if (v) begin
      c_exp_data  = d;
      c_exp_waddr = c_addr;
    end
  endtask

  task automatic check_all();
    chk("a_wr_en", a_wr_en, exp_wr);
    chk("b_wr_en", b_wr_en, exp_wr);
    chk("a_timeout", a_timeout_err, exp_to);
    chk("b_timeout", b_timeout_err, exp_to);
    chk("a_partial", a_partial, q.size() != 0);
    chk("b_partial", b_partial, q.size() != 0);
    chk("a_frame", a_frame_done, exp_wr && exp_waddr == DEPTH_AB - 1);
    chk("b_frame", b_frame_done, exp_wr && exp_waddr == DEPTH_AB - 1);
    if (exp_wr) begin
      chk("a_data", a_wr_data, exp_wl);
      chk("b_data", b_wr_data, exp_wm);
      chk("a_addr", a_wr_addr, exp_waddr);
      chk("b_addr", b_wr_addr, exp_waddr);
    end
    chk("c_wr_en", c_wr_en, c_exp_wr);
    chk("c_partial", c_partial, 0);
    chk("c_frame", c_frame_done, c_exp_wr && c_exp_waddr == DEPTH_C - 1);
    if (c_exp_wr) begin
      chk("c_data", c_wr_data, c_exp_data);
      chk("c_addr", c_wr_addr, c_exp_waddr);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit c,
                      input bit cv, input logic [7:0] cd);
    rx_valid = v; rx_data = d; clear = c;
    c_valid = cv; c_data = cd;
    @(posedge clk);
    model_ab(v, d, c);
    model_c(cv, cd);
    #1;
    check_all();
    rx_valid = 1'b0; clear = 1'b0; c_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1, d, 0, 0, 8'h00);
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(0, 8'h00, 0, 0, 8'h00);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_en"}, a_wr_en, 0);
    chk({tag, "_a_data"}, a_wr_data, 0);
    chk({tag, "_a_addr"}, a_wr_addr, 0);
    chk({tag, "_a_fd"}, a_frame_done, 0);
    chk({tag, "_a_to"}, a_timeout_err, 0);
    chk({tag, "_a_part"}, a_partial, 0);
    chk({tag, "_b_data"}, b_wr_data, 0);
    chk({tag, "_b_part"}, b_partial, 0);
    chk({tag, "_c_en"}, c_wr_en, 0);
    chk({tag, "_c_data"}, c_wr_data, 0);
    chk({tag, "_c_addr"}, c_wr_addr, 0);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; clear = 1'b0;
    c_valid = 1'b0; c_data = '0; c_clear = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: LSB-first packing, gapped bytes, 1-clock latency
    send(8'h11); idle_n(5);
    send(8'h22); idle_n(5);
    send(8'h33);
    chk("t1_en", a_wr_en, 1);
    chk("t1_data", a_wr_data, 24'h332211);
    chk("t1_addr", a_wr_addr, 0);
    idle_n(5);
    send(8'h44); send(8'h55); send(8'h66);
    chk("t1_addr2", a_wr_addr, 1);
    chk("t1_data2", a_wr_data, 24'h665544);
    idle_n(2);

    // 2: MSB-first lane order
    send(8'hAA); send(8'hBB); send(8'hCC);
    chk("t2_msb", b_wr_data, 24'hAABBCC);
    chk("t2_lsb", a_wr_data, 24'hCCBBAA);
    idle_n(2);

    // 3: address wrap and frame_done
    step(0, 8'h00, 1, 0, 8'h00);
    for (int w = 0; w < 5; w++) begin
      send(8'($urandom)); send(8'($urandom)); send(8'($urandom));
      chk("t3_addr", a_wr_addr, w % 4);
      chk("t3_fd", a_frame_done, (w % 4) == 3);
      idle_n(1);
    end

    // 4: timeout drops partial word, address unchanged
    send(8'h01); send(8'h02);
    idle_n(9);
    chk("t4_pre_to", a_timeout_err, 0);
    chk("t4_pre_part", a_partial, 1);
    idle_n(1);
    chk("t4_to", a_timeout_err, 1);
    chk("t4_part", a_partial, 0);
    chk("t4_no_wr", a_wr_en, 0);
    idle_n(1);
    chk("t4_to_pulse", a_timeout_err, 0);
    send(8'h05); send(8'h06); send(8'h07);
    chk("t4_data", a_wr_data, 24'h070605);
    chk("t4_addr", a_wr_addr, 1);

    // 5: byte arriving during WRITE is kept
    send(8'hA1); send(8'hA2); send(8'hA3);
    chk("t5_data_a", a_wr_data, 24'hA3A2A1);
    send(8'hB1);
    chk("t5_part", a_partial, 1);
    send(8'hB2); send(8'hB3);
    chk("t5_data_b", a_wr_data, 24'hB3B2B1);
    chk("t5_addr_b", a_wr_addr, 3);
    chk("t5_fd", a_frame_done, 1);
    idle_n(1);

    // 6: clear drops byte, resets address; clear during WRITE
    step(0, 8'h00, 1, 0, 8'h00);
    for (int i = 0; i < 6; i++) send(8'(i + 16));
    send(8'h77);
    step(1, 8'h88, 1, 0, 8'h00);
    chk("t6_part", a_partial, 0);
    chk("t6_no_wr", a_wr_en, 0);
    send(8'h31); send(8'h32); send(8'h33);
    chk("t6_addr0", a_wr_addr, 0);
    chk("t6_data", a_wr_data, 24'h333231);
    send(8'h41); send(8'h42); send(8'h43);
    step(0, 8'h00, 1, 0, 8'h00);
    send(8'h51); send(8'h52); send(8'h53);
    chk("t6_wr_clr", a_wr_addr, 0);
    send(8'h61);
    #2;
    reset = 1'b1;
    #1;
    check_zero("midreset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // back-to-back single-byte words
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 0, 1, 8'(i + 8'h90));
      chk("c_b2b_en", c_wr_en, 1);
      chk("c_b2b_addr", c_wr_addr, i % DEPTH_C);
    end
    idle_n(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit v, c, cv;
      v  = (i < 300) ? ($urandom_range(0, 99) < 60)
                     : ($urandom_range(0, 15) == 0);
      c  = ($urandom_range(0, 63) == 0);
      cv = ($urandom_range(0, 1) == 1);
      step(v, 8'($urandom), c, cv, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
